// File: rtl/yutorina_bus_slave_regfile_pkg.sv
// Shared constants and FSM encoding for the generic bus-slave register file.
// Word width, active-low enable levels, rw values and wait-counter width.
package yutorina_bus_slave_regfile_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ZERO = '0;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        BUS_SLAVE_IDLE  = 2'd0,
        BUS_SLAVE_WAIT  = 2'd1,
        BUS_SLAVE_READY = 2'd2
    } bus_slave_state_e;

endpackage

// File: rtl/yutorina_bus_slave_wait_ctrl.sv
// Request FSM: samples cs_/as_, counts wait states, aborts on a dropped strobe.
// Emits a commit strobe on the edge that enters READY, plus a registered rdy_.
module yutorina_bus_slave_wait_ctrl
    import yutorina_bus_slave_regfile_pkg::*;
#(
    parameter int ADDR_W      = 2,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              commit,
    output logic              cmd_rw,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [WORD_W-1:0] cmd_wr_data,
    output logic              rdy_
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    bus_slave_state_e        state;
    bus_slave_state_e        state_nx;
    logic [WAIT_CNT_W-1:0]   cnt;
    logic [WAIT_CNT_W-1:0]   cnt_nx;
    logic                    load;
    logic                    req;
    logic                    rw_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [WORD_W-1:0]       wr_data_q;

    assign req = (cs_ == ENABLE_) && (as_ == ENABLE_);

    // With zero wait states the commit happens on the sampling edge itself,
    // so the live request is forwarded while still in IDLE.
    assign cmd_rw      = (state == BUS_SLAVE_IDLE) ? rw      : rw_q;
    assign cmd_addr    = (state == BUS_SLAVE_IDLE) ? addr    : addr_q;
    assign cmd_wr_data = (state == BUS_SLAVE_IDLE) ? wr_data : wr_data_q;

    // Next-state, counter and commit decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        load     = 1'b0;
        unique case (state)
            BUS_SLAVE_IDLE: begin
                if (req) begin
                    load   = 1'b1;
                    cnt_nx = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = BUS_SLAVE_READY;
                        commit   = 1'b1;
                    end else begin
                        state_nx = BUS_SLAVE_WAIT;
                    end
                end
            end
            BUS_SLAVE_WAIT: begin
                if (!req) begin
                    state_nx = BUS_SLAVE_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_ONE) begin
                    state_nx = BUS_SLAVE_READY;
                    commit   = 1'b1;
                    cnt_nx   = cnt - CNT_ONE;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            BUS_SLAVE_READY: begin
                state_nx = BUS_SLAVE_IDLE;
            end
            default: begin
                state_nx = BUS_SLAVE_IDLE;
            end
        endcase
    end

    // State, counter, request latch and ready strobe registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= BUS_SLAVE_IDLE;
            cnt       <= '0;
            rw_q      <= READ;
            addr_q    <= '0;
            wr_data_q <= ZERO;
            rdy_      <= DISABLE_;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rdy_  <= commit ? ENABLE_ : DISABLE_;
            if (load) begin
                rw_q      <= rw;
                addr_q    <= addr;
                wr_data_q <= wr_data;
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_slave_regfile.sv
// Bus-slave register bank with registered read data and wait-state control.
// Optional YUTORINA_BUS_SLAVE_ACCESS_CNT_EN maps an access counter to the top index.
module yutorina_bus_slave_regfile
    import yutorina_bus_slave_regfile_pkg::*;
#(
    parameter int ADDR_W      = 2,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data,
    output logic              rdy_
);

    localparam int REG_NUM = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

    logic              commit;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [WORD_W-1:0] cmd_wr_data;
    logic [WORD_W-1:0] bank [REG_NUM];
    logic [WORD_W-1:0] rd_word;
    logic              bank_we;

    yutorina_bus_slave_wait_ctrl #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctrl (
        .clk         (clk),
        .reset_      (reset_),
        .cs_         (cs_),
        .as_         (as_),
        .rw          (rw),
        .addr        (addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_wr_data (cmd_wr_data),
        .rdy_        (rdy_)
    );

`ifdef YUTORINA_BUS_SLAVE_ACCESS_CNT_EN
    logic [WORD_W-1:0] acc_cnt;

    // The top index is read-only: writes there are acknowledged but dropped.
    assign bank_we = commit && (cmd_rw == WRITE) && (cmd_addr != LAST_IDX);
    assign rd_word = (cmd_addr == LAST_IDX) ? acc_cnt : bank[cmd_addr];

    // Count every completed access; a read sees the value before its own bump.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            acc_cnt <= ZERO;
        end else if (commit) begin
            acc_cnt <= acc_cnt + 32'd1;
        end
    end
`else
    assign bank_we = commit && (cmd_rw == WRITE);
    assign rd_word = bank[cmd_addr];
`endif

    // Register bank write port, committed on READY entry only.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < REG_NUM; i++) begin
                bank[i] <= ZERO;
            end
        end else if (bank_we) begin
            bank[cmd_addr] <= cmd_wr_data;
        end
    end

    // Read data is valid only in the READY cycle of a read, zero otherwise.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_data <= ZERO;
        end else begin
            rd_data <= (commit && (cmd_rw == READ)) ? rd_word : ZERO;
        end
    end

endmodule

// File: tb/tb_yutorina_bus_slave_regfile.sv
// Randomized self-checking bench for two slaves (0 and 2 wait states)
// against an array-based model of the register bank and access count.
module tb_yutorina_bus_slave_regfile;

    logic        clk = 1'b0;
    logic        reset_;
    logic [1:0]  cs_v;
    logic [1:0]  as_v;
    logic [1:0]  rw_v;
    logic [1:0][1:0]  addr_v;
    logic [1:0][31:0] wd_v;
    logic [1:0][31:0] rd_v;
    logic [1:0]  rdy_v;

    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [2][4];
    logic [31:0] acnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    yutorina_bus_slave_regfile #(.ADDR_W(2), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_(reset_), .cs_(cs_v[0]), .as_(as_v[0]),
        .rw(rw_v[0]), .addr(addr_v[0]), .wr_data(wd_v[0]),
        .rd_data(rd_v[0]), .rdy_(rdy_v[0])
    );

    yutorina_bus_slave_regfile #(.ADDR_W(2), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset_(reset_), .cs_(cs_v[1]), .as_(as_v[1]),
        .rw(rw_v[1]), .addr(addr_v[1]), .wr_data(wd_v[1]),
        .rd_data(rd_v[1]), .rdy_(rdy_v[1])
    );

    function automatic int wc(input int s);
        return (s == 1) ? 2 : 0;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            acnt[s] = 32'd0;
            for (int i = 0; i < 4; i++) mem[s][i] = 32'd0;
        end
    endtask

    // Completed access: returns what the read should deliver (0 for writes).
    task automatic model_commit(input int s, input logic r, input logic [1:0] a,
                                input logic [31:0] d, output logic [31:0] e);
        e = 32'd0;
        if (r) begin
`ifdef YUTORINA_BUS_SLAVE_ACCESS_CNT_EN
            e = (a == 2'd3) ? acnt[s] : mem[s][a];
`else
            e = mem[s][a];
`endif
        end else begin
`ifdef YUTORINA_BUS_SLAVE_ACCESS_CNT_EN
            if (a != 2'd3) mem[s][a] = d;
`else
            mem[s][a] = d;
`endif
        end
        acnt[s] = acnt[s] + 32'd1;
    endtask

    // Drives one request and records what the slave did over its window.
    task automatic run_access(input int s, input logic r, input logic [1:0] a,
                              input logic [31:0] d, input int abort_k,
                              output int edge_no, output bit pre_ok,
                              output int rdy_cycle, output int rdy_cnt,
                              output logic [31:0] rd_at, output int stray);
        @(negedge clk);
        pre_ok = (rdy_v[s] === 1'b1) && (rd_v[s] === 32'd0);
        cs_v[s] = 1'b0; as_v[s] = 1'b0;
        rw_v[s] = r; addr_v[s] = a; wd_v[s] = d;
        @(posedge clk);
        edge_no = int'(cyc);
        rdy_cycle = -1; rdy_cnt = 0; rd_at = 32'd0; stray = 0;
        for (int k = 1; k <= wc(s) + 1; k++) begin
            @(negedge clk);
            if (rdy_v[s] === 1'b0) begin
                rdy_cnt++;
                if (rdy_cycle < 0) rdy_cycle = k;
                rd_at = rd_v[s];
                cs_v[s] = 1'b1; as_v[s] = 1'b1;
            end else if (rd_v[s] !== 32'd0) begin
                stray++;
            end
            if (k == abort_k) begin
                if ($urandom_range(0, 1) == 0) as_v[s] = 1'b1;
                else cs_v[s] = 1'b1;
            end
        end
        cs_v[s] = 1'b1; as_v[s] = 1'b1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rdy_v !== 2'b11) begin
                n_bad++; $display("FAIL reset_rdy: got %b want 11", rdy_v);
            end
            n_cmp++;
            if (rd_v !== 64'd0) begin
                n_bad++; $display("FAIL reset_rd: got %h want 0", rd_v);
            end
        end
        reset_ = 1'b1;
        model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 4; a++) begin
                int en, rc, cn, st; bit po; logic [31:0] rd, e;
                run_access(s, 1'b1, 2'(a), 32'd0, 0, en, po, rc, cn, rd, st);
                model_commit(s, 1'b1, 2'(a), 32'd0, e);
                n_cmp++;
                if (rd !== e || cn != 1) begin
                    n_bad++;
                    $display("FAIL post_reset_read s%0d i%0d: got %h/%0d want %h/1", s, a, rd, cn, e);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int en, rc, cn, st; bit po; logic [31:0] rd, e;
        run_access(1, 1'b0, 2'd1, 32'hDEADBEEF, 0, en, po, rc, cn, rd, st);
        model_commit(1, 1'b0, 2'd1, 32'hDEADBEEF, e);
        n_cmp++;
        if (rc != 3 || cn != 1) begin
            n_bad++; $display("FAIL wr_latency: got cyc %0d cnt %0d want 3/1", rc, cn);
        end
        n_cmp++;
        if (rd !== 32'd0 || st != 0) begin
            n_bad++; $display("FAIL wr_rd_data: got %h stray %0d want 0/0", rd, st);
        end
        run_access(1, 1'b1, 2'd1, 32'd0, 0, en, po, rc, cn, rd, st);
        model_commit(1, 1'b1, 2'd1, 32'd0, e);
        n_cmp++;
        if (rd !== e || rc != 3 || cn != 1) begin
            n_bad++; $display("FAIL rd_back: got %h cyc %0d want %h cyc 3", rd, rc, e);
        end
        n_cmp++;
        if (!po) begin
            n_bad++; $display("FAIL rd_idle_out: got 0 want 1");
        end
    endtask

    task automatic test_abort();
        int en, rc, cn, st; bit po; logic [31:0] rd, e;
        run_access(1, 1'b0, 2'd2, 32'h12345678, 1, en, po, rc, cn, rd, st);
        n_cmp++;
        if (cn != 0) begin
            n_bad++; $display("FAIL abort_rdy: got %0d strobes want 0", cn);
        end
        run_access(1, 1'b1, 2'd2, 32'd0, 0, en, po, rc, cn, rd, st);
        model_commit(1, 1'b1, 2'd2, 32'd0, e);
        n_cmp++;
        if (rd !== e || cn != 1) begin
            n_bad++; $display("FAIL abort_readback: got %h want %h", rd, e);
        end
    endtask

    task automatic test_back_to_back();
        int e1, e2, rc1, rc2, cn, st; bit po; logic [31:0] rd, e;
        run_access(0, 1'b0, 2'd0, 32'hA5A5A5A5, 0, e1, po, rc1, cn, rd, st);
        model_commit(0, 1'b0, 2'd0, 32'hA5A5A5A5, e);
        run_access(0, 1'b1, 2'd0, 32'd0, 0, e2, po, rc2, cn, rd, st);
        model_commit(0, 1'b1, 2'd0, 32'd0, e);
        n_cmp++;
        if (e2 - e1 != 2 || rc1 != 1 || rc2 != 1) begin
            n_bad++;
            $display("FAIL b2b_timing: got gap %0d cyc %0d/%0d want 2 1/1", e2 - e1, rc1, rc2);
        end
        n_cmp++;
        if (rd !== e || !po) begin
            n_bad++; $display("FAIL b2b_data: got %h idle %0d want %h 1", rd, po, e);
        end
    endtask

    task automatic test_reset_mid();
        int en, rc, cn, st; bit po; logic [31:0] rd, e;
        @(negedge clk);
        cs_v[1] = 1'b0; as_v[1] = 1'b0;
        rw_v[1] = 1'b0; addr_v[1] = 2'd3; wd_v[1] = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        reset_ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rdy_v[1] !== 1'b1) begin
                n_bad++; $display("FAIL mid_reset_rdy: got %b want 1", rdy_v[1]);
            end
        end
        cs_v[1] = 1'b1; as_v[1] = 1'b1;
        reset_ = 1'b1;
        model_clear();
        run_access(1, 1'b1, 2'd3, 32'd0, 0, en, po, rc, cn, rd, st);
        model_commit(1, 1'b1, 2'd3, 32'd0, e);
        n_cmp++;
        if (rd !== e || cn != 1) begin
            n_bad++; $display("FAIL mid_reset_idx3: got %h want %h", rd, e);
        end
        run_access(1, 1'b0, 2'd1, 32'h5A5A0001, 0, en, po, rc, cn, rd, st);
        model_commit(1, 1'b0, 2'd1, 32'h5A5A0001, e);
        @(negedge clk);
        cs_v[1] = 1'b0; as_v[1] = 1'b0; rw_v[1] = 1'b1; addr_v[1] = 2'd1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        model_commit(1, 1'b1, 2'd1, 32'd0, e);
        n_cmp++;
        if (rdy_v[1] !== 1'b0 || rd_v[1] !== e) begin
            n_bad++; $display("FAIL ready_read: got %b/%h want 0/%h", rdy_v[1], rd_v[1], e);
        end
        reset_ = 1'b0;
        #1;
        n_cmp++;
        if (rdy_v[1] !== 1'b1 || rd_v[1] !== 32'd0) begin
            n_bad++; $display("FAIL async_reset: got %b/%h want 1/0", rdy_v[1], rd_v[1]);
        end
        cs_v[1] = 1'b1; as_v[1] = 1'b1;
        @(negedge clk);
        reset_ = 1'b1;
        model_clear();
    endtask

`ifdef YUTORINA_BUS_SLAVE_ACCESS_CNT_EN
    task automatic test_access_cnt();
        int en, rc, cn, st; bit po; logic [31:0] rd, e;
        @(negedge clk);
        reset_ = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            logic r; logic [1:0] a; logic [31:0] d;
            r = 1'($urandom_range(0, 1));
            a = 2'($urandom_range(0, 2));
            d = $urandom;
            run_access(1, r, a, d, 0, en, po, rc, cn, rd, st);
            model_commit(1, r, a, d, e);
        end
        run_access(1, 1'b0, 2'd3, 32'h99, 0, en, po, rc, cn, rd, st);
        model_commit(1, 1'b0, 2'd3, 32'h99, e);
        n_cmp++;
        if (cn != 1 || rc != 3) begin
            n_bad++; $display("FAIL cnt_wr_ack: got %0d/%0d want 1/3", cn, rc);
        end
        run_access(1, 1'b1, 2'd3, 32'd0, 0, en, po, rc, cn, rd, st);
        n_cmp++;
        if (rd !== 32'd6) begin
            n_bad++; $display("FAIL cnt_read: got %0d want 6", rd);
        end
        model_commit(1, 1'b1, 2'd3, 32'd0, e);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int s, ab, en, rc, cn, st; bit po;
            logic r; logic [1:0] a; logic [31:0] d, rd, e;
            s = int'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            ab = (s == 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_access(s, r, a, d, ab, en, po, rc, cn, rd, st);
            n_cmp++;
            if (!po || st != 0) begin
                n_bad++; $display("FAIL rnd_idle s%0d #%0d: idle %0d stray %0d want 1/0", s, i, po, st);
            end
            if (ab != 0) begin
                n_cmp++;
                if (cn != 0) begin
                    n_bad++; $display("FAIL rnd_abort s%0d #%0d: got %0d strobes want 0", s, i, cn);
                end
            end else begin
                model_commit(s, r, a, d, e);
                n_cmp++;
                if (cn != 1 || rc != wc(s) + 1 || rd !== e) begin
                    n_bad++;
                    $display("FAIL rnd_access s%0d #%0d: got %0d/%0d/%h want 1/%0d/%h", s, i, cn, rc, rd, wc(s) + 1, e);
                end
            end
        end
    endtask

    initial begin
        reset_ = 1'b0;
        cs_v = 2'b11; as_v = 2'b11; rw_v = 2'b11;
        addr_v = '0; wd_v = '0;
        model_clear();
        test_reset();
        test_write_read();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef YUTORINA_BUS_SLAVE_ACCESS_CNT_EN
        test_access_cnt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
